div_sequencer: RTL and testbench
================================

Name: div_sequencer

Overview:
Iterative radix-2 integer divide controller serving the execute stage's div/mod requests. Latches operands when the execute stage raises its divide enable and runs a 32-step restoring division. Holds the result and a complete flag until the execute stage hands the instruction to the memory stage. Aborts on any pipeline flush. Supplies the execute stage's div_complete input.

Parameters:
WIDTH, 32, operand/result width
CNT_W, 5, iteration counter width (log2 WIDTH)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
div_enable  in  1  execute stage holds a valid div/mod instruction (level, held until handoff)
div_signed  in  1  1 = signed div/mod, 0 = unsigned
div_op_mod  in  1  1 = return remainder, 0 = return quotient
div_src1  in  WIDTH  dividend (rj value)
div_src2  in  WIDTH  divisor (rkd value)
div_accept  in  1  execute stage handoff this cycle (es_to_ms_valid & ms_allowin)
flush  in  1  OR of excp/ertn/refetch/icacop/idle flush
div_complete  out  1  result valid and stable
div_result  out  WIDTH  quotient or remainder per latched div_op_mod
div_busy  out  1  iteration in progress

Behaviour:
- Reset (async, active-high): state IDLE, count 0, div_complete 0, div_busy 0, div_result 0, all operand/partial registers 0.
- div_complete = (state == DONE). div_busy = (state == BUSY). Both registered, no combinational input-to-output path.
- Priority in every state: flush > div_enable drop > div_accept > normal progress.
- IDLE, div_enable=1 and flush=0:
  - Latch |src1|, |src2| (absolute values only when div_signed), quotient sign = sign1 XOR sign2, remainder sign = sign1, and div_op_mod.
  - src2 == 0: go to DONE with quotient = all ones and remainder = src1 unmodified (defined team value).
  - Otherwise: go to BUSY with count = 0 and partial remainder = 0.
- BUSY, each cycle:
  - Shift {rem, dividend} left 1 bit.
  - trial = rem - |divisor| at WIDTH+1 bits.
  - If trial >= 0: rem = trial and set the quotient LSB; otherwise clear the quotient LSB.
  - count++.
  - When count == WIDTH-1: apply sign fix-up and go to DONE. Negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set.
- Latency: enable first sampled at edge 0. Normal divide reaches DONE after edge 32, so div_complete is high from cycle 33. Divide-by-zero reaches DONE after edge 0, so div_complete is high from cycle 1.
- DONE: div_result held stable. On div_accept, go to IDLE, so div_complete drops the next cycle. A back-to-back divide (enable still high) starts from IDLE one cycle later.
- div_accept outside DONE: ignored.
- div_enable low while in BUSY or DONE with no flush: abort to IDLE (defensive); div_result keeps its last value.
- flush in any state: IDLE next edge, div_complete 0, no result update.
- Signed overflow 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. This falls out of unsigned magnitudes with WIDTH-bit wrap; no special case.
- All arithmetic is unsigned WIDTH-bit except the WIDTH+1-bit trial subtract. Negation is two's complement with wrap.

Decomposition:
- Shared package (mycpu.h): state encoding localparams DIV_IDLE=2'd0, DIV_BUSY=2'd1, DIV_DONE=2'd2.
- Shared package (mycpu.h): DIV_BYZERO_Q constant = all ones.
- Sub-module div_step: combinational one-bit restoring step. Inputs rem, dividend MSB, divisor. Outputs new rem and quotient bit.
- Top level holds the FSM, counter, operand registers and sign fix-up.

Test Plan:
- Unsigned 100 / 7 with div_op_mod=0: div_complete rises in cycle 33, div_result = 14. Repeat with div_op_mod=1: div_result = 2.
- Signed -7 / 2: quotient 0xFFFFFFFD. With div_op_mod=1: remainder 0xFFFFFFFF. Signed 0x80000000 / 0xFFFFFFFF: q = 0x80000000, r = 0.
- Divide by zero 5 / 0: div_complete in cycle 1, q = 0xFFFFFFFF, r = 5.
- flush pulsed in cycle 10 of BUSY: div_busy 0 next cycle, div_complete never asserts. A following 9 / 3 returns 3 with complete in cycle 33 after its enable.
- DONE held with div_accept low for 5 cycles: div_result and div_complete stay stable. div_accept high with div_enable still high: complete 0 next cycle, new divide starts the cycle after.
- Async reset asserted mid-BUSY between clock edges: outputs go to 0 immediately. After release, IDLE; a fresh 100 / 7 completes correctly.

Source files
------------

// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the iterative divide controller: FSM encoding and
// the architectural divide-by-zero quotient.
package div_sequencer_pkg;

  localparam int DIV_DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  localparam logic [DIV_DEF_WIDTH-1:0] DIV_BYZERO_Q = '1;

endpackage

// File: rtl/div_sequencer_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dvd_msb_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] shifted;

  assign shifted = {rem_i, dvd_msb_i};
  assign q_bit_o = (shifted >= {1'b0, divisor_i});
  // The true difference is below the divisor, so a WIDTH-bit subtract is exact.
  assign rem_o   = shifted[WIDTH-1:0] - (q_bit_o ? divisor_i : '0);

endmodule

// File: rtl/div_sequencer.sv
// Radix-2 restoring divide sequencer for the execute stage: latches operands,
// iterates WIDTH steps, then holds the signed-corrected result until handoff.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int WIDTH = DIV_DEF_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_enable,
  input  logic             div_signed,
  input  logic             div_op_mod,
  input  logic [WIDTH-1:0] div_src1,
  input  logic [WIDTH-1:0] div_src2,
  input  logic             div_accept,
  input  logic             flush,
  output logic             div_complete,
  output logic             div_busy,
  output logic [WIDTH-1:0] div_result
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             mod_q, mod_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             complete_q, complete_d;
  logic             busy_q, busy_d;

  logic             sign1, sign2;
  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH-1:0] step_rem, step_quo, quo_fix, rem_fix;
  logic             step_qbit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .dvd_msb_i (dvd_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_qbit)
  );

  assign sign1    = div_signed & div_src1[WIDTH-1];
  assign sign2    = div_signed & div_src2[WIDTH-1];
  assign mag1     = sign1 ? -div_src1 : div_src1;
  assign mag2     = sign2 ? -div_src2 : div_src2;
  assign step_quo = {dvd_q[WIDTH-2:0], step_qbit};
  assign quo_fix  = q_neg_q ? -step_quo : step_quo;
  assign rem_fix  = r_neg_q ? -step_rem : step_rem;

  always_comb begin
    // NOTE: every _d gets a hold default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    mod_d    = mod_q;
    result_d = result_q;

    unique case (state_q)
      DIV_IDLE: begin
        if (!flush && div_enable) begin
          dvd_d   = mag1;
          dvs_d   = mag2;
          q_neg_d = sign1 ^ sign2;
          r_neg_d = sign1;
          mod_d   = div_op_mod;
          cnt_d   = '0;
          rem_d   = '0;
          if (div_src2 == '0) begin
            state_d  = DIV_DONE;
            result_d = div_op_mod ? div_src1 : WIDTH'(DIV_BYZERO_Q);
          end else begin
            state_d  = DIV_BUSY;
          end
        end
      end
      DIV_BUSY: begin
        if (flush || !div_enable) begin
          state_d = DIV_IDLE;
        end else begin
          rem_d = step_rem;
          dvd_d = step_quo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d  = DIV_DONE;
            result_d = mod_q ? rem_fix : quo_fix;
          end
        end
      end
      DIV_DONE: begin
        if (flush || !div_enable || div_accept) state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  // Flags are decoded from the next state so both outputs come straight from flops.
  assign complete_d = (state_d == DIV_DONE);
  assign busy_d     = (state_d == DIV_BUSY);

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= DIV_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      mod_q      <= 1'b0;
      result_q   <= '0;
      complete_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      mod_q      <= mod_d;
      result_q   <= result_d;
      complete_q <= complete_d;
      busy_q     <= busy_d;
    end
  end

  assign div_complete = complete_q;
  assign div_busy     = busy_q;
  assign div_result   = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: stimulus pushes expected result and
// completion cycle, a negedge monitor checks each rising div_complete.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        div_enable = 1'b0;
  logic        div_signed = 1'b0;
  logic        div_op_mod = 1'b0;
  logic [31:0] div_src1 = '0;
  logic [31:0] div_src2 = '0;
  logic        div_accept = 1'b0;
  logic        flush = 1'b0;
  logic        div_complete;
  logic        div_busy;
  logic [31:0] div_result;

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic prev_c = 1'b0;

  div_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .div_enable   (div_enable),
    .div_signed   (div_signed),
    .div_op_mod   (div_op_mod),
    .div_src1     (div_src1),
    .div_src2     (div_src2),
    .div_accept   (div_accept),
    .flush        (flush),
    .div_complete (div_complete),
    .div_busy     (div_busy),
    .div_result   (div_result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every rising div_complete must match the oldest expectation.
  always @(negedge clk) begin
    if (div_complete && !prev_c) begin
      if (sb.size() == 0) begin
        check("unexpected_complete", 32'(div_complete), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", div_result, e.res);
        check("latency", 32'(cyc), 32'(e.due));
      end
    end
    prev_c = div_complete;
  end

  task automatic start(input logic s, input logic m, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    div_enable = 1'b1;
    div_signed = s;
    div_op_mod = m;
    div_src1   = a;
    div_src2   = b;
  endtask

  task automatic wait_complete();
    int n = 0;
    while (!div_complete && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!div_complete) check("complete_timeout", 32'(div_complete), 32'd1);
  endtask

  task automatic handoff();
    div_accept = 1'b1;
    @(posedge clk); #1;
    div_accept = 1'b0;
    div_enable = 1'b0;
    check("complete_drop", 32'(div_complete), 32'd0);
  endtask

  task automatic do_div(input logic s, input logic m, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    start(s, m, a, b);
    sb.push_back('{exp, cyc + 1 + lat});
    wait_complete();
    handoff();
  endtask

  initial begin
    #2;
    check("reset_complete", 32'(div_complete), 32'd0);
    check("reset_busy", 32'(div_busy), 32'd0);
    check("reset_result", div_result, 32'd0);
    #10 reset = 1'b0;

    // Unsigned, signed, overflow and divide-by-zero vectors
    do_div(1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 32);
    do_div(1'b0, 1'b1, 32'd100, 32'd7, 32'd2, 32);
    do_div(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32);
    do_div(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32);
    do_div(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32);
    do_div(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32);
    do_div(1'b0, 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    do_div(1'b0, 1'b1, 32'd5, 32'd0, 32'd5, 0);

    // Flush ten cycles into BUSY: no completion, then a clean 9 / 3
    start(1'b0, 1'b0, 32'd100, 32'd7);
    repeat (11) @(posedge clk);
    #1;
    check("busy_before_flush", 32'(div_busy), 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    div_enable = 1'b0;
    check("busy_after_flush", 32'(div_busy), 32'd0);
    check("complete_after_flush", 32'(div_complete), 32'd0);
    repeat (40) @(posedge clk);
    #1;
    check("idle_after_flush", 32'(div_complete), 32'd0);
    do_div(1'b0, 1'b0, 32'd9, 32'd3, 32'd3, 32);

    // DONE held without accept, then accept with enable still high
    start(1'b0, 1'b0, 32'd100, 32'd7);
    sb.push_back('{32'd14, cyc + 33});
    wait_complete();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_result", div_result, 32'd14);
      check("hold_complete", 32'(div_complete), 32'd1);
    end
    div_accept = 1'b1;
    sb.push_back('{32'd14, cyc + 1 + 1 + 32});
    @(posedge clk); #1;
    div_accept = 1'b0;
    check("b2b_complete_drop", 32'(div_complete), 32'd0);
    check("b2b_not_busy_yet", 32'(div_busy), 32'd0);
    @(posedge clk); #1;
    check("b2b_busy", 32'(div_busy), 32'd1);
    wait_complete();
    handoff();

    // Asynchronous reset between edges while BUSY
    start(1'b0, 1'b0, 32'd100, 32'd7);
    repeat (6) @(posedge clk);
    #3;
    check("busy_before_reset", 32'(div_busy), 32'd1);
    reset = 1'b1;
    #1;
    check("async_busy", 32'(div_busy), 32'd0);
    check("async_complete", 32'(div_complete), 32'd0);
    check("async_result", div_result, 32'd0);
    div_enable = 1'b0;
    @(posedge clk); #3;
    reset = 1'b0;
    do_div(1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 32);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
